tmds_channel_decoder: RTL and testbench
=======================================

# tmds_channel_decoder

Receive-side counterpart of the DVI transmitter: decodes one TMDS channel of 10-bit parallel words from the input deserializer into 8-bit pixel data plus the DE and C0/C1 control bits. It also recovers 10-bit word alignment by hunting for control-token runs and pulsing a bitslip request back to the deserializer. Three instances, one per channel, feed the future HDMI-input passthrough path ahead of the overlay mux. All run on `pix_clk`.

## Interface
Parameters:
- `CTRL_RUN`, 8: consecutive control tokens required to declare (or re-confirm) alignment; 2..255.
- `SEARCH_WINDOW`, 4096: cycles spent in SEARCH before requesting a bitslip; ≤ 65535.
- `LOSS_WINDOW`, 4096: cycles in LOCKED without a qualifying token run before lock is dropped; ≤ 65535.
- `SLIP_WAIT`, 16: settle cycles after a bitslip pulse; ≥ 1.

Ports:
- `clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `tmds_word`  in  10  deserialized word, sampled every `clk` edge; bit 0 is first on the wire.
- `data`  out  8  decoded pixel byte; 0 when `de`=0.
- `de`  out  1  data enable.
- `c0`, `c1`  out  1 each  control bits from the last control token.
- `locked`  out  1  word alignment established.
- `bitslip`  out  1  one-cycle request to shift the deserializer by one bit.
- `slip_count`  out  4  bitslips issued, 0..9, wraps 9→0.

## Operation
- Control tokens: 0x354→C1C0=00, 0x0AB→01, 0x154→10, 0x2AB→11. Any other word is a data word.
- Data decode: if q[9]=1, invert q[7:0]. Then d[0]=q'[0]. For i=1..7, d[i]=q'[i]^q'[i-1] when q[8]=1, else ~(q'[i]^q'[i-1]).
- Run counter (8-bit, saturating at `CTRL_RUN`):
  - +1 on each token sampled.
  - Cleared on each data word.
  - A "qualifying run" is the edge where it reaches `CTRL_RUN`.
- FSM states: SEARCH, SLIP_WAIT, LOCKED. Reset enters SEARCH.
- SEARCH:
  - Window counter increments every cycle.
  - A qualifying run moves to LOCKED.
  - Otherwise, when the window counter reaches `SEARCH_WINDOW`-1: pulse `bitslip`, increment `slip_count` mod 10, move to SLIP_WAIT.
  - If a qualifying run and window expiry occur on the same edge, the run wins: go to LOCKED, no bitslip.
- SLIP_WAIT:
  - Counts `SLIP_WAIT` cycles, then returns to SEARCH with the run and window counters cleared.
  - Input is ignored during this state.
- LOCKED:
  - Loss counter clears on every qualifying run.
  - The run counter restarts its count after saturation once any data word is seen.
  - Loss counter reaching `LOSS_WINDOW`-1 returns the FSM to SEARCH with counters cleared.
  - Dropping lock issues no bitslip.
- Output gating, based on the next state:
  - Next state LOCKED, token sampled: `de`=0, `data`=0, `c1`/`c0` take the token value.
  - Next state LOCKED, data word sampled: `de`=1, `data`=decoded byte, `c1`/`c0` hold.
  - Next state not LOCKED: `de`=0, `data`=0, `c1`/`c0` hold.
- `locked` = (state == LOCKED), registered.
- `slip_count` does not reset on lock or loss; only `rst_n` clears it.

## Timing
- Reset values: `data`=0, `de`=0, `c0`=0, `c1`=0, `locked`=0, `bitslip`=0, `slip_count`=0; FSM in SEARCH; all counters 0.
- Reset mid-operation: all of the above apply on the next edge, no residual pulse.
- Latency: one cycle. Outputs after edge k reflect `tmds_word` sampled at edge k.
- `locked` rises after the edge that samples the `CTRL_RUN`-th consecutive token. The outputs from that same token are already valid (c-bits update).
- `bitslip` is high for exactly one cycle, `SEARCH_WINDOW` cycles after SEARCH entry. Minimum spacing between pulses is `SEARCH_WINDOW`+`SLIP_WAIT` cycles.
- `locked` falls after the edge where the loss counter hits `LOSS_WINDOW`-1. `de` is 0 from that same edge.

## Test plan
- Reset, then 8× 0x354 → `locked`=1 after the 8th edge. `c1`/`c0`=00, `de`=0, `bitslip` never pulsed.
- Locked; feed 0x100, 0x3FF, 0x200, then 0x2AB → one cycle later, outputs in order:
  - `data`/`de` = 0x00/1, 0x00/1, 0xFF/1;
  - then `de`=0 with `c1`=1, `c0`=1.
- Constant 0x155 from reset with `SEARCH_WINDOW`=64, `SLIP_WAIT`=16:
  - `bitslip` pulses at cycles 64, 144, 224, …;
  - `slip_count` wraps 9→0 after the 10th pulse;
  - `locked` stays 0, `de` stays 0.
- Run of 7 tokens, one data word, then 7 tokens → no lock. Then an 8th consecutive token → lock.
- 8th token lands on the same edge as SEARCH window expiry → `locked`=1, no `bitslip`, `slip_count` unchanged.
- Locked, then only data words for `LOSS_WINDOW` cycles:
  - `locked`=0 and `de`=0 thereafter, no `bitslip`;
  - re-lock after 8 tokens;
  - `rst_n` low for one cycle mid-stream clears all outputs.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: turns 10-bit deserialized words into pixel data and
// control bits, and hunts for word alignment using control-token runs,
// requesting a bitslip from the deserializer when no run shows up in time.
module tmds_channel_decoder #(
    parameter int unsigned CTRL_RUN      = 8,
    parameter int unsigned SEARCH_WINDOW = 4096,
    parameter int unsigned LOSS_WINDOW   = 4096,
    parameter int unsigned SLIP_WAIT     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] tmds_word,
    output logic [7:0] data,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic       locked,
    output logic       bitslip,
    output logic [3:0] slip_count
);

    localparam int unsigned RUN_W = 8;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [CNT_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [3:0]         slip_q, slip_d;
    logic               bitslip_q, bitslip_d;
    logic [7:0]         data_q, data_d;
    logic               de_q, de_d;
    logic               c0_q, c0_d;
    logic               c1_q, c1_d;
    logic               locked_q, locked_d;

    logic               is_tok_c;
    logic [1:0]         ctrl_c;
    logic [7:0]         unmasked_c;
    logic [7:0]         dec_c;
    logic [RUN_W-1:0]   run_next_c;
    logic               qual_c;

    // Control-token detection
    always_comb begin
        is_tok_c = 1'b1;
        ctrl_c   = 2'b00;
        case (tmds_word)
            10'h354: ctrl_c = 2'b00;
            10'h0AB: ctrl_c = 2'b01;
            10'h154: ctrl_c = 2'b10;
            10'h2AB: ctrl_c = 2'b11;
            default: is_tok_c = 1'b0;
        endcase
    end

    // Transition-minimised data decode
    always_comb begin
        unmasked_c = tmds_word[9] ? ~tmds_word[7:0] : tmds_word[7:0];
        dec_c      = 8'h00;
        dec_c[0]   = unmasked_c[0];
        for (int i = 1; i < 8; i++) begin
            dec_c[i] = tmds_word[8] ? (unmasked_c[i] ^ unmasked_c[i-1])
                                    : ~(unmasked_c[i] ^ unmasked_c[i-1]);
        end
    end

    // Saturating token-run counter; qualifying run is the step onto CTRL_RUN
    always_comb begin
        if (!is_tok_c) begin
            run_next_c = '0;
        end else if (run_q >= RUN_W'(CTRL_RUN)) begin
            run_next_c = run_q;
        end else begin
            run_next_c = run_q + RUN_W'(1);
        end
        qual_c = is_tok_c && (run_q == RUN_W'(CTRL_RUN - 1));
    end

    // Alignment FSM next state and output gating on the next state
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        win_d     = win_q;
        loss_d    = loss_q;
        wait_d    = wait_q;
        slip_d    = slip_q;
        bitslip_d = 1'b0;
        data_d    = 8'h00;
        de_d      = 1'b0;
        c0_d      = c0_q;
        c1_d      = c1_q;

        case (state_q)
            ST_SEARCH: begin
                if (qual_c) begin
                    state_d = ST_LOCKED;
                    run_d   = run_next_c;
                    win_d   = '0;
                    loss_d  = '0;
                end else if (win_q == CNT_W'(SEARCH_WINDOW - 1)) begin
                    state_d   = ST_SLIP_WAIT;
                    bitslip_d = 1'b1;
                    slip_d    = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
                    run_d     = '0;
                    win_d     = '0;
                    wait_d    = '0;
                end else begin
                    run_d = run_next_c;
                    win_d = win_q + CNT_W'(1);
                end
            end
            ST_SLIP_WAIT: begin
                run_d = '0;
                if (wait_q == CNT_W'(SLIP_WAIT - 1)) begin
                    state_d = ST_SEARCH;
                    wait_d  = '0;
                    win_d   = '0;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_LOCKED: begin
                run_d = run_next_c;
                if (qual_c) begin
                    loss_d = '0;
                end else if (loss_q == CNT_W'(LOSS_WINDOW - 1)) begin
                    state_d = ST_SEARCH;
                    run_d   = '0;
                    win_d   = '0;
                    loss_d  = '0;
                end else begin
                    loss_d = loss_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_SEARCH;
                run_d   = '0;
                win_d   = '0;
                loss_d  = '0;
                wait_d  = '0;
            end
        endcase

        if (state_d == ST_LOCKED) begin
            if (is_tok_c) begin
                c1_d = ctrl_c[1];
                c0_d = ctrl_c[0];
            end else begin
                de_d   = 1'b1;
                data_d = dec_c;
            end
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            win_q     <= '0;
            loss_q    <= '0;
            wait_q    <= '0;
            slip_q    <= '0;
            bitslip_q <= 1'b0;
            data_q    <= 8'h00;
            de_q      <= 1'b0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            win_q     <= win_d;
            loss_q    <= loss_d;
            wait_q    <= wait_d;
            slip_q    <= slip_d;
            bitslip_q <= bitslip_d;
            data_q    <= data_d;
            de_q      <= de_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            locked_q  <= locked_d;
        end
    end

    assign data       = data_q;
    assign de         = de_q;
    assign c0         = c0_q;
    assign c1         = c1_q;
    assign locked     = locked_q;
    assign bitslip    = bitslip_q;
    assign slip_count = slip_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: stimulus pushes expected outputs
// from a behavioural model, a monitor pops and compares every cycle.
module tb_tmds_channel_decoder;

    localparam int unsigned CR  = 8;
    localparam int unsigned SW  = 64;
    localparam int unsigned LW  = 48;
    localparam int unsigned SWT = 16;

    localparam int HUNT    = 0;
    localparam int SETTLE  = 1;
    localparam int ALIGNED = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] tmds_word;
    logic [7:0] data;
    logic       de, c0, c1, locked, bitslip;
    logic [3:0] slip_count;

    always #5 clk = ~clk;

    tmds_channel_decoder #(
        .CTRL_RUN     (CR),
        .SEARCH_WINDOW(SW),
        .LOSS_WINDOW  (LW),
        .SLIP_WAIT    (SWT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tmds_word (tmds_word),
        .data      (data),
        .de        (de),
        .c0        (c0),
        .c1        (c1),
        .locked    (locked),
        .bitslip   (bitslip),
        .slip_count(slip_count)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       de;
        logic       c1;
        logic       c0;
        logic       locked;
        logic       bitslip;
        logic [3:0] slips;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Behavioural model state
    int         m_mode    = HUNT;
    int         m_run     = 0;
    int         m_elapsed = 0;
    int         m_slips   = 0;
    obs_t       m_out     = '0;

    function automatic int tok_idx(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] b;
        logic [7:0] d;
        b    = w[9] ? ~w[7:0] : w[7:0];
        d    = 8'h00;
        d[0] = b[0];
        for (int i = 1; i < 8; i++) d[i] = b[i] ^ b[i-1] ^ ~w[8];
        return d;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom);
        while (tok_idx(w) >= 0) w = 10'($urandom);
        return w;
    endfunction

    task automatic model_update(input logic r, input logic [9:0] w);
        int         t;
        logic       qual;
        logic [1:0] tv;
        t    = tok_idx(w);
        qual = 1'b0;
        m_out.bitslip = 1'b0;
        if (!r) begin
            m_mode    = HUNT;
            m_run     = 0;
            m_elapsed = 0;
            m_slips   = 0;
            m_out     = '0;
        end else begin
            if (m_mode != SETTLE) begin
                m_run = (t >= 0) ? m_run + 1 : 0;
                qual  = (m_run == int'(CR));
            end
            case (m_mode)
                HUNT: begin
                    m_elapsed++;
                    if (qual) begin
                        m_mode = ALIGNED; m_elapsed = 0;
                    end else if (m_elapsed == int'(SW)) begin
                        m_out.bitslip = 1'b1;
                        m_slips   = (m_slips + 1) % 10;
                        m_mode    = SETTLE;
                        m_elapsed = 0;
                        m_run     = 0;
                    end
                end
                SETTLE: begin
                    m_elapsed++;
                    if (m_elapsed == int'(SWT)) begin
                        m_mode = HUNT; m_elapsed = 0; m_run = 0;
                    end
                end
                default: begin
                    if (qual) begin
                        m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == int'(LW)) begin
                            m_mode = HUNT; m_elapsed = 0; m_run = 0;
                        end
                    end
                end
            endcase
            m_out.data = 8'h00;
            m_out.de   = 1'b0;
            if (m_mode == ALIGNED) begin
                if (t >= 0) begin
                    tv = 2'(t);
                    m_out.c1 = tv[1];
                    m_out.c0 = tv[0];
                end else begin
                    m_out.de   = 1'b1;
                    m_out.data = ref_decode(w);
                end
            end
            m_out.locked = (m_mode == ALIGNED);
            m_out.slips  = 4'(m_slips);
        end
    endtask

    task automatic step(input logic r, input logic [9:0] w);
        @(negedge clk);
        rst_n     = r;
        tmds_word = w;
        model_update(r, w);
        exp_q.push_back(m_out);
    endtask

    // Monitor: compare DUT outputs against the oldest expected entry
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{data: data, de: de, c1: c1, c0: c0, locked: locked,
                      bitslip: bitslip, slips: slip_count};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d: got data=%h de=%b c1=%b c0=%b locked=%b bitslip=%b slips=%0d, want data=%h de=%b c1=%b c0=%b locked=%b bitslip=%b slips=%0d",
                             cyc, a.data, a.de, a.c1, a.c0, a.locked, a.bitslip, a.slips,
                             e.data, e.de, e.c1, e.c0, e.locked, e.bitslip, e.slips);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int kind;
        int len;
        logic [9:0] tk;
        rst_n     = 1'b0;
        tmds_word = 10'h000;

        repeat (3) step(1'b0, 10'h000);

        // lock on 0x354, then decode examples ending in a 11 token
        repeat (CR) step(1'b1, 10'h354);
        step(1'b1, 10'h100);
        step(1'b1, 10'h3FF);
        step(1'b1, 10'h200);
        step(1'b1, 10'h2AB);

        // lose lock on data only, relock, reset mid-stream
        repeat (LW + 4) step(1'b1, rand_data());
        repeat (CR) step(1'b1, 10'h0AB);
        repeat (5) step(1'b1, rand_data());
        step(1'b0, rand_data());
        repeat (5) step(1'b1, rand_data());

        // no tokens: periodic bitslips, slip counter wraps
        step(1'b0, 10'h000);
        repeat (SW + 10 * (SW + SWT) + 20) step(1'b1, 10'h155);

        // broken run does not lock, completed run does
        step(1'b0, 10'h000);
        repeat (CR - 1) step(1'b1, 10'h154);
        step(1'b1, rand_data());
        repeat (CR - 1) step(1'b1, 10'h154);
        step(1'b1, 10'h154);
        repeat (4) step(1'b1, rand_data());

        // qualifying run coincides with search window expiry
        step(1'b0, 10'h000);
        repeat (SW - CR) step(1'b1, rand_data());
        repeat (CR) step(1'b1, 10'h2AB);
        repeat (4) step(1'b1, rand_data());

        // randomized token/data bursts with occasional reset
        repeat (80) begin
            kind = int'($urandom_range(0, 19));
            if (kind == 0) begin
                step(1'b0, rand_data());
            end else if (kind < 10) begin
                len = int'($urandom_range(1, 12));
                case ($urandom_range(0, 3))
                    0: tk = 10'h354;
                    1: tk = 10'h0AB;
                    2: tk = 10'h154;
                    default: tk = 10'h2AB;
                endcase
                repeat (len) step(1'b1, tk);
            end else begin
                len = int'($urandom_range(1, 90));
                repeat (len) step(1'b1, rand_data());
            end
        end

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
